// File: rtl/mat_result_serializer.sv
// rtl/mat_result_serializer.sv - captures a packed 4x4 result matrix on a start edge
// and streams its entries out over a valid/ready handshake.
module mat_result_serializer #(
    parameter int WIDTH   = 10,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH*ENTRIES-1:0]   mat_in,
    input  logic                       start,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       done,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t                     state_q, state_d;
    logic [WIDTH*ENTRIES-1:0]   cap_q, cap_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       start_q, start_d;
    logic                       trigger;

    // Entry 0 sits in the most significant field of the packed bus.
    logic [WIDTH-1:0] ent [ENTRIES];
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign ent[g] = cap_q[WIDTH*(ENTRIES-g)-1 -: WIDTH];
    end

    assign trigger = start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            start_q <= start_d;
        end
    end

    // Outputs depend only on registered state; out_ready steers the next state alone.
    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        idx_d     = idx_q;
        start_d   = start;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_LOAD;
                    cap_d   = mat_in;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = ent[idx_q];
                out_idx   = idx_q;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mat_result_serializer.sv
// tb/tb_mat_result_serializer.sv - self-checking bench for mat_result_serializer
// using a table of stream cases, randomized backpressure and a queue-based model.
module tb_mat_result_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] mat_in;
    logic         start;
    logic         out_ready;
    logic         out_valid;
    logic [9:0]   out_data;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         done;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mat_result_serializer #(.WIDTH(10), .ENTRIES(16), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mat_in    (mat_in),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] m;
        int           mode;
        logic [9:0]   first;
        logic [9:0]   last;
        int           done_c;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] pack_lin(input int base, input int step);
        logic [159:0] m = '0;
        for (int k = 0; k < 16; k++) m = {m[149:0], 10'(base + step * k)};
        return m;
    endfunction

    // Begin a stream from IDLE: one low cycle on start, then a rising edge.
    task automatic start_stream(input logic [159:0] m);
        start = 1'b0;
        @(negedge clk);
        mat_in = m;
        start  = 1'b1;
    endtask

    // Follows one stream from its trigger cycle. Modes: 0 ready high, 1 random ready,
    // 2 three-cycle stall at idx 5, 3 start retoggled mid-stream.
    task automatic follow(input logic [159:0] m, input int mode, input int exp_done,
                          input int abort_at, output logic [9:0] first_d,
                          output logic [9:0] last_d, output bit aborted);
        logic [9:0] exp_q[$];
        int  beats = 0;
        int  stall = 0;
        bit  got_done = 0;
        bit  rdy;
        aborted = 0;
        first_d = '0;
        last_d  = '0;
        for (int k = 0; k < 16; k++) exp_q.push_back(m[159-10*k -: 10]);
        for (int c = 1; c < 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("load_valid", 32'(out_valid), 32'd0);
                chk("load_busy", 32'(busy), 32'd1);
                mat_in = {16{10'h3FF}};
            end else if (done) begin
                chk("done_beats", beats, 16);
                chk("done_busy_valid", {busy, out_valid}, 32'd0);
                if (exp_done > 0) chk("done_cycle", c, exp_done);
                got_done = 1;
                break;
            end else begin
                chk("send_valid_busy", {out_valid, busy}, 32'd3);
                if (out_valid && beats < 16)
                    chk("beat", {out_data, out_idx, out_last},
                        {exp_q[beats], 4'(beats), 1'(beats == 15)});
                if (beats == 0) first_d = out_data;
                if (beats == 15) last_d = out_data;
                if (abort_at >= 0 && beats == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("abort_outputs", {out_valid, busy, done}, 32'd0);
                    @(negedge clk);
                    chk("abort_hold", {out_valid, busy, done, out_last}, 32'd0);
                    rst = 1'b0;
                    aborted = 1;
                    return;
                end
                case (mode)
                    1:       rdy = ($urandom % 4) != 0;
                    2:       rdy = !(beats == 5 && stall < 3);
                    default: rdy = 1'b1;
                endcase
                if (!rdy) stall++;
                if (mode == 3 && c == 6) start = 1'b0;
                if (mode == 3 && c == 7) start = 1'b1;
                out_ready = rdy;
                if (out_valid && rdy) beats++;
            end
        end
        if (!got_done) chk("stream_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    // With start held high, nothing may happen.
    task automatic idle_hold(input int n);
        logic act = 1'b0;
        repeat (n) begin
            @(negedge clk);
            act = act | busy | out_valid | done;
        end
        chk("no_retrigger", 32'(act), 32'd0);
    endtask

    initial begin
        logic [159:0] m;
        logic [9:0]   f, l;
        bit           ab;

        tab[0] = '{pack_lin(1, 1),    0, 10'd1,   10'd16,  18};
        tab[1] = '{pack_lin(1, 1),    2, 10'd1,   10'd16,  21};
        tab[2] = '{pack_lin(29, 0),   0, 10'h01D, 10'h01D, 18};
        tab[3] = '{pack_lin(1023, -1), 0, 10'h3FF, 10'h3F0, 18};
        tab[4] = '{pack_lin(1, 1),    3, 10'd1,   10'd16,  18};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; mat_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid_busy_done", {out_valid, busy, done, out_last}, 32'd0);
        chk("reset_data_idx", {out_data, out_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {out_valid, busy, done}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            start_stream(tab[i].m);
            follow(tab[i].m, tab[i].mode, tab[i].done_c, -1, f, l, ab);
            chk($sformatf("tab%0d_first", i), 32'(f), 32'(tab[i].first));
            chk($sformatf("tab%0d_last", i), 32'(l), 32'(tab[i].last));
            idle_hold(20);
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 5; k++) m = {m[127:0], 32'($urandom)};
            start_stream(m);
            follow(m, 1, 0, -1, f, l, ab);
            idle_hold(3);
        end

        out_ready = 1'b1;
        m = pack_lin(1, 1);
        start_stream(m);
        follow(m, 0, 0, 9, f, l, ab);
        chk("abort_taken", 32'(ab), 32'd1);
        m = pack_lin(50, 3);
        mat_in = m;
        follow(m, 0, 18, -1, f, l, ab);
        chk("restart_first", 32'(f), 32'd50);
        idle_hold(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
